marie_control_unit: RTL
=======================

Name: marie_control_unit

Overview:
- Microsequenced controller for the accumulator datapath: owns PC, IR, MAR, MBR and AC.
- Runs fetch / decode / execute against the single-port synchronous main memory (1-cycle read latency, write on the clock edge while write enable is high).
- Implements the 10-instruction accumulator ISA below; sits between the memory and the debug/output pins.

Parameters:
ADDR_W, 12, address field width and PC/MAR width; the memory address is zero-extended to 16 bits.
DATA_W, 16, data width of AC, MBR and IR and of the memory words.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  level; sampled in IDLE, begins execution at PC=0.
mem_addr  output  16  memory address = {zero-pad, MAR}.
mem_wdata  output  DATA_W  memory write data = AC.
mem_we  output  1  memory write enable.
mem_rdata  input  DATA_W  memory read data; valid the cycle after an address is presented with mem_we=0.
out_data  output  DATA_W  AC value captured by OUTPUT.
out_valid  output  1  one-cycle pulse when out_data is updated.
halted  output  1  high in HALTED.
illegal_op  output  1  sticky; set on an undefined opcode.
pc  output  ADDR_W  debug view of PC.
ac  output  DATA_W  debug view of AC.
ir  output  DATA_W  debug view of IR.

Behaviour:
- Reset (reset=0, async): state=IDLE; PC, MAR, MBR, IR, AC, out_data = 0; out_valid, halted, illegal_op, mem_we = 0. Reset mid-instruction aborts it; no partial memory write survives past the reset edge.
- Instruction format: IR[15:12] is the opcode, IR[11:0] is the operand X.
- States: IDLE, FETCH_ADDR, FETCH_READ, FETCH_IR, DECODE, EXEC_READ, EXEC_MBR, EXEC_ALU, EXEC_WRITE, HALTED.
- IDLE: when start=1, go to FETCH_ADDR; otherwise hold.
- FETCH_ADDR: MAR<=PC.
- FETCH_READ: memory samples MAR.
- FETCH_IR: IR<=mem_rdata; PC<=PC+1, wrapping 0xFFF->0x000 with no flag.
- DECODE: MAR<=IR[11:0], then by opcode:
  - 1 LOAD, 3 ADD, 4 SUBT, 5 AND: go to EXEC_READ.
  - 2 STORE: go to EXEC_WRITE.
  - 6 OUTPUT: out_data<=AC, out_valid=1 next cycle only, go to FETCH_ADDR.
  - 7 HALT: go to HALTED.
  - 8 SKIPCOND: skip (PC<=PC+1) when IR[11:10]=00 and AC<0 signed, or =01 and AC==0, or =10 and AC>0 signed; IR[11:10]=11 never skips. Then go to FETCH_ADDR.
  - 9 JUMP: PC<=IR[11:0], go to FETCH_ADDR.
  - A CLEAR: AC<=0, go to FETCH_ADDR.
  - 0 and B-F: illegal_op<=1, go to HALTED.
- EXEC_READ: memory samples MAR; go to EXEC_MBR.
- EXEC_MBR: MBR<=mem_rdata; go to EXEC_ALU.
- EXEC_ALU: AC<=MBR / AC+MBR / AC-MBR / AC&MBR for LOAD / ADD / SUBT / AND; arithmetic is modulo 2^16 with no carry/borrow flag; go to FETCH_ADDR.
- EXEC_WRITE: mem_we=1 and mem_wdata=AC for exactly this cycle; go to FETCH_ADDR.
- mem_we is 0 in every other state.
- Latency in clocks, counted from the FETCH_ADDR cycle:
  - 7: LOAD, ADD, SUBT, AND.
  - 5: STORE.
  - 4: OUTPUT, JUMP, SKIPCOND, CLEAR, HALT (HALT reaches HALTED on its 5th clock).
- HALTED: halted=1; all registers hold; start is ignored; only reset exits.
- start is ignored in every state except IDLE.
- A self-modifying STORE into the next fetch address takes effect: that fetch follows the write.

Test Plan:
- Program: M[0]=0x1010, M[1]=0x3011, M[2]=0x2012, M[3]=0x6000, M[4]=0x7000; data M[0x10]=0x0005, M[0x11]=0x0007; pulse start -> M[0x12]=0x000C, one out_valid pulse with out_data=0x000C, halted=1 exactly 28 clocks after the start-accept edge, pc=0x005.
- SUBT wrap: AC=0x0003, M[X]=0x0005, SUBT X -> AC=0xFFFE, no other output changes.
- SKIPCOND sweep:
  - AC=0x8000 with 0x8000 -> PC advances by 2.
  - AC=0x0000 with 0x8400 -> PC advances by 2.
  - AC=0x0001 with 0x8400 -> PC advances by 1.
  - 0x8C00 never skips.
- JUMP 0xFFF with M[0xFFF]=0x9000 -> PC wraps to 0x000 after FETCH_IR, then jumps to 0x000; no X or stall.
- Opcode 0xF at M[0] -> illegal_op=1 and halted=1; AC and memory unchanged; start pulses ignored afterwards.
- Assert reset=0 during EXEC_WRITE of a STORE -> all outputs return to reset values asynchronously; after release plus start, execution restarts at PC=0.

Source files
------------

// File: rtl/marie_control_unit.sv
// Microsequenced fetch/decode/execute controller for the MARIE accumulator
// datapath. It owns PC, IR, MAR, MBR and AC and drives a single-port
// synchronous memory with a one-cycle read latency.
module marie_control_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_ADDR, S_FETCH_READ, S_FETCH_IR, S_DECODE,
    S_EXEC_READ, S_EXEC_MBR, S_EXEC_ALU, S_EXEC_WRITE, S_HALTED
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mbr_q, mbr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic                mem_we_q, mem_we_d;

  logic [3:0]          opcode;
  logic [1:0]          skip_cond;
  logic                ac_neg, ac_zero, skip;

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign skip_cond = ir_q[ADDR_W-1 -: 2];
  assign ac_neg    = ac_q[DATA_W-1];
  assign ac_zero   = (ac_q == '0);

  // Skip test on the signed accumulator; condition 11 never skips.
  always_comb begin
    skip = 1'b0;
    case (skip_cond)
      2'b00:   skip = ac_neg;
      2'b01:   skip = ac_zero;
      2'b10:   skip = !ac_neg && !ac_zero;
      default: skip = 1'b0;
    endcase
  end

  // Next-state and next-register computation for the microsequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    mbr_d       = mbr_q;
    ir_d        = ir_q;
    ac_d        = ac_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE:       if (start) state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: begin
        mar_d   = pc_q;
        state_d = S_FETCH_READ;
      end
      S_FETCH_READ: state_d = S_FETCH_IR;
      S_FETCH_IR: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        mar_d   = ir_q[ADDR_W-1:0];
        state_d = S_FETCH_ADDR;
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT, OP_AND: state_d = S_EXEC_READ;
          OP_STORE: begin
            // Write enable is registered so it is high for exactly EXEC_WRITE.
            mem_we_d = 1'b1;
            state_d  = S_EXEC_WRITE;
          end
          OP_OUT: begin
            out_data_d  = ac_q;
            out_valid_d = 1'b1;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end
          OP_SKIP:  if (skip) pc_d = pc_q + PC_ONE;
          OP_JUMP:  pc_d = ir_q[ADDR_W-1:0];
          OP_CLEAR: ac_d = '0;
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = S_HALTED;
          end
        endcase
      end
      S_EXEC_READ: state_d = S_EXEC_MBR;
      S_EXEC_MBR: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC_ALU;
      end
      S_EXEC_ALU: begin
        case (opcode)
          OP_ADD:  ac_d = ac_q + mbr_q;
          OP_SUBT: ac_d = ac_q - mbr_q;
          OP_AND:  ac_d = ac_q & mbr_q;
          default: ac_d = mbr_q;
        endcase
        state_d = S_FETCH_ADDR;
      end
      S_EXEC_WRITE: state_d = S_FETCH_ADDR;
      S_HALTED:     state_d = S_HALTED;
      default:      state_d = S_IDLE;
    endcase
  end

  // State and register update; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      mar_q       <= '0;
      mbr_q       <= '0;
      ir_q        <= '0;
      ac_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      mbr_q       <= mbr_d;
      ir_q        <= ir_d;
      ac_q        <= ac_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign mem_addr   = 16'(mar_q);
  assign mem_wdata  = ac_q;
  assign mem_we     = mem_we_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;
  assign pc         = pc_q;
  assign ac         = ac_q;
  assign ir         = ir_q;

endmodule
